// File: rtl/burst_expand.sv
// Expands {burst_len, base_addr} descriptors into one word address per beat,
// sustaining one beat per cycle with back-to-back bursts chained without bubbles.
module burst_expand #(
    parameter int AddrWidth         = 64,
    parameter int DataWidthBytesLog = 6,
    parameter int BurstLenWidth     = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [BurstLenWidth+AddrWidth-1:0] burst_dout,
    input  logic                               burst_empty_n,
    output logic                               burst_read,
    output logic [AddrWidth:0]                 addr_din,
    input  logic                               addr_full_n,
    output logic                               addr_write
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Step is a whole data word, so the byte-offset bits of base_addr never change.
    localparam logic [AddrWidth-1:0] AddrStep = AddrWidth'(1) << DataWidthBytesLog;

    state_e                   state_q, state_d;
    logic [AddrWidth-1:0]     cur_addr_q, cur_addr_d;
    logic [BurstLenWidth-1:0] remaining_q, remaining_d;

    logic active;
    logic last_beat;

    assign active     = (state_q == ACTIVE);
    assign last_beat  = (remaining_q == '0);
    assign addr_write = active & addr_full_n;
    assign addr_din   = {active & last_beat, cur_addr_q};
    assign burst_read = burst_empty_n & (~active | (addr_write & last_beat));

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no latch is inferred.
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        if (burst_read) begin
            // Covers both the idle pop and the chained pop on a last beat.
            state_d     = ACTIVE;
            cur_addr_d  = burst_dout[AddrWidth-1:0];
            remaining_d = burst_dout[BurstLenWidth+AddrWidth-1:AddrWidth];
        end else if (addr_write) begin
            if (last_beat) begin
                state_d = IDLE;
            end else begin
                cur_addr_d  = cur_addr_q + AddrStep;
                remaining_d = remaining_q - BurstLenWidth'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the same pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
        end
    end

endmodule
